// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes,
// state and opcode-class encodings, and datapath select constants.
package ctrl_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE = 4'd0,
    CLS_R    = 4'd1,
    CLS_I    = 4'd2,
    CLS_LUI  = 4'd3,
    CLS_LW   = 4'd4,
    CLS_SW   = 4'd5,
    CLS_BR   = 4'd6,
    CLS_JAL  = 4'd7,
    CLS_JALR = 4'd8
  } op_class_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_LINK = 2'b10;

  localparam logic [1:0] JSEL_NONE = 2'b00;
  localparam logic [1:0] JSEL_JAL  = 2'b01;
  localparam logic [1:0] JSEL_JALR = 2'b10;

  // Wait-counter width: enough to hold TIMEOUT_CYCLES, never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps a raw opcode onto an instruction class, honouring which optional
// instruction groups are built in. Anything unrecognised is illegal.
module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_JUMPS = 1,
  parameter int SUPPORT_LUI   = 1
) (
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       illegal
);

  // Decode opcode into a class; unsupported groups fall through to CLS_NONE.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    op_class = CLS_NONE;
    case (opcode)
      OPC_R:    op_class = CLS_R;
      OPC_I:    op_class = CLS_I;
      OPC_LW:   op_class = CLS_LW;
      OPC_SW:   op_class = CLS_SW;
      OPC_BR:   op_class = CLS_BR;
      OPC_LUI:  if (SUPPORT_LUI != 0)   op_class = CLS_LUI;
      OPC_JAL:  if (SUPPORT_JUMPS != 0) op_class = CLS_JAL;
      OPC_JALR: if (SUPPORT_JUMPS != 0) op_class = CLS_JALR;
      default:  op_class = CLS_NONE;
    endcase
    illegal = (op_class == CLS_NONE);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on
// memory handshakes with a time-out, freezes on hazard stalls and traps
// on illegal opcodes. Outputs are decoded from state and registered class.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SUPPORT_JUMPS  = 1,
  parameter int SUPPORT_LUI    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       stall_in,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       alu_src,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic [1:0] jsel,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state_o
);

  localparam int            CW        = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  op_class_e     cls_q, cls_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;

  op_class_e     dec_class;
  logic          dec_illegal;
  logic [CW-1:0] cnt_inc;
  logic          wait_expired;

  opcode_classifier #(
    .SUPPORT_JUMPS (SUPPORT_JUMPS),
    .SUPPORT_LUI   (SUPPORT_LUI)
  ) u_classifier (
    .opcode   (opcode),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  // State, opcode class, wait counter and sticky trap flags.
  // NOTE: non-blocking (<=) so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NONE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, class capture and wait counting; a stall freezes all of it.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = '0;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    cnt_inc      = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;
    wait_expired = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

    if (stall_in) begin
      cnt_d = cnt_q;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            state_d = ST_DECODE;
          end else if (wait_expired) begin
            state_d   = ST_TRAP;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DECODE: begin
          cls_d = dec_class;
          if (dec_illegal) begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_R, CLS_I, CLS_LUI, CLS_JAL, CLS_JALR: state_d = ST_WB;
            CLS_LW, CLS_SW:                           state_d = ST_MEM;
            CLS_BR:                                   state_d = ST_FETCH;
            default:                                  state_d = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state_d = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
          end else if (wait_expired) begin
            state_d   = ST_TRAP;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WB:   state_d = ST_FETCH;
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase
    end
  end

  // Datapath controls from state and registered class; writes gated by stall.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = M2R_ALU;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;
    branch     = 1'b0;
    jsel       = JSEL_NONE;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        pc_write = imem_ack && !stall_in;
        ir_write = imem_ack && !stall_in;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R:   alu_op = ALU_FUNCT;
          CLS_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_FUNCT;
          end
          CLS_LUI: begin
            alu_src = 1'b1;
            alu_op  = ALU_LUI;
          end
          CLS_LW, CLS_SW: alu_src = 1'b1;
          CLS_BR: begin
            branch = 1'b1;
            alu_op = ALU_BR;
          end
          CLS_JAL: begin
            jsel     = JSEL_JAL;
            pc_write = !stall_in;
          end
          CLS_JALR: begin
            jsel     = JSEL_JALR;
            alu_src  = 1'b1;
            pc_write = !stall_in;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (cls_q == CLS_LW);
        mem_write = (cls_q == CLS_SW) && !stall_in;
      end
      ST_WB: begin
        reg_write = !stall_in;
        if (cls_q == CLS_LW) begin
          mem_to_reg = M2R_MEM;
        end else if (cls_q == CLS_JAL || cls_q == CLS_JALR) begin
          mem_to_reg = M2R_LINK;
        end
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Two instances share stimulus:
// dut (TIMEOUT_CYCLES=4, jumps on) and dut_nj (default time-out, jumps off).
// Outputs are packed into one vector per instance and compared per cycle.
module tb_multicycle_controller;

  // Hand-written opcodes
  localparam logic [6:0] T_R    = 7'b0110011;
  localparam logic [6:0] T_I    = 7'b0010011;
  localparam logic [6:0] T_LUI  = 7'b0110111;
  localparam logic [6:0] T_LW   = 7'b0000011;
  localparam logic [6:0] T_SW   = 7'b0100011;
  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_JALR = 7'b1100111;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_BAD  = 7'b1111111;

  // Observation vector layout
  localparam logic [19:0] B_IMEM  = 20'h1 << 19;
  localparam logic [19:0] B_DMEM  = 20'h1 << 18;
  localparam logic [19:0] B_PCW   = 20'h1 << 17;
  localparam logic [19:0] B_IRW   = 20'h1 << 16;
  localparam logic [19:0] B_SRC   = 20'h1 << 15;
  localparam logic [19:0] M_MEM   = 20'h1 << 13;
  localparam logic [19:0] M_PC    = 20'h2 << 13;
  localparam logic [19:0] B_REGW  = 20'h1 << 12;
  localparam logic [19:0] B_MRD   = 20'h1 << 11;
  localparam logic [19:0] B_MWR   = 20'h1 << 10;
  localparam logic [19:0] A_BR    = 20'h1 << 8;
  localparam logic [19:0] A_FN    = 20'h2 << 8;
  localparam logic [19:0] A_LUI   = 20'h3 << 8;
  localparam logic [19:0] B_BR    = 20'h1 << 7;
  localparam logic [19:0] J_JAL   = 20'h1 << 5;
  localparam logic [19:0] J_JALR  = 20'h2 << 5;
  localparam logic [19:0] B_ILL   = 20'h1 << 4;
  localparam logic [19:0] B_TO    = 20'h1 << 3;
  localparam logic [19:0] S_IDLE  = 20'd0;
  localparam logic [19:0] S_FETCH = 20'd1;
  localparam logic [19:0] S_DEC   = 20'd2;
  localparam logic [19:0] S_EXEC  = 20'd3;
  localparam logic [19:0] S_MEM   = 20'd4;
  localparam logic [19:0] S_WB    = 20'd5;
  localparam logic [19:0] S_TRAP  = 20'd6;
  localparam logic [19:0] F_ACK   = S_FETCH | B_IMEM | B_PCW | B_IRW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       stall_in = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;

  logic imem_req, dmem_req, pc_write, ir_write, alu_src, reg_write;
  logic mem_read, mem_write, branch, illegal, timeout;
  logic [1:0] mem_to_reg, alu_op, jsel;
  logic [2:0] state_o;

  logic nj_imem_req, nj_dmem_req, nj_pc_write, nj_ir_write, nj_alu_src, nj_reg_write;
  logic nj_mem_read, nj_mem_write, nj_branch, nj_illegal, nj_timeout;
  logic [1:0] nj_mem_to_reg, nj_alu_op, nj_jsel;
  logic [2:0] nj_state_o;

  logic [19:0] obs, nj_obs;
  int checks = 0;
  int errors = 0;

  assign obs = {imem_req, dmem_req, pc_write, ir_write, alu_src, mem_to_reg,
                reg_write, mem_read, mem_write, alu_op, branch, jsel,
                illegal, timeout, state_o};
  assign nj_obs = {nj_imem_req, nj_dmem_req, nj_pc_write, nj_ir_write, nj_alu_src,
                   nj_mem_to_reg, nj_reg_write, nj_mem_read, nj_mem_write, nj_alu_op,
                   nj_branch, nj_jsel, nj_illegal, nj_timeout, nj_state_o};

  always #5 clk = ~clk;

  multicycle_controller #(
    .TIMEOUT_CYCLES (4),
    .SUPPORT_JUMPS  (1),
    .SUPPORT_LUI    (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .stall_in (stall_in),
    .imem_ack (imem_ack), .dmem_ack (dmem_ack),
    .imem_req (imem_req), .dmem_req (dmem_req), .pc_write (pc_write),
    .ir_write (ir_write), .alu_src (alu_src), .mem_to_reg (mem_to_reg),
    .reg_write (reg_write), .mem_read (mem_read), .mem_write (mem_write),
    .alu_op (alu_op), .branch (branch), .jsel (jsel), .illegal (illegal),
    .timeout (timeout), .state_o (state_o)
  );

  multicycle_controller #(
    .TIMEOUT_CYCLES (16),
    .SUPPORT_JUMPS  (0),
    .SUPPORT_LUI    (1)
  ) dut_nj (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .stall_in (stall_in),
    .imem_ack (imem_ack), .dmem_ack (dmem_ack),
    .imem_req (nj_imem_req), .dmem_req (nj_dmem_req), .pc_write (nj_pc_write),
    .ir_write (nj_ir_write), .alu_src (nj_alu_src), .mem_to_reg (nj_mem_to_reg),
    .reg_write (nj_reg_write), .mem_read (nj_mem_read), .mem_write (nj_mem_write),
    .alu_op (nj_alu_op), .branch (nj_branch), .jsel (nj_jsel), .illegal (nj_illegal),
    .timeout (nj_timeout), .state_o (nj_state_o)
  );

  // Hold reset for two edges, release just after a rising edge (cycle 0 = IDLE).
  task automatic do_reset();
    rst_n    = 1'b0;
    stall_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    opcode   = T_R;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 20'd0) begin
      errors++;
      $display("FAIL reset dut: got %h expected %h", obs, 20'd0);
    end
    checks++;
    if (nj_obs !== 20'd0) begin
      errors++;
      $display("FAIL reset dut_nj: got %h expected %h", nj_obs, 20'd0);
    end
  endtask

  task automatic test_add();
    logic [19:0] exp [6];
    exp = '{S_IDLE, F_ACK, S_DEC, S_EXEC | A_FN, S_WB | B_REGW, F_ACK};
    opcode = T_R; imem_ack = 1'b1; dmem_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL add cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [19:0] exp [10];
    exp = '{S_IDLE, F_ACK, S_DEC, S_EXEC | B_SRC,
            S_MEM | B_DMEM | B_MRD, S_MEM | B_DMEM | B_MRD,
            S_MEM | B_DMEM | B_MRD, S_MEM | B_DMEM | B_MRD,
            S_WB | B_REGW | M_MEM, F_ACK};
    opcode = T_LW; imem_ack = 1'b1; dmem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dmem_ack = (i == 7);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_illegal();
    logic [19:0] exp [8];
    exp = '{S_IDLE, F_ACK, S_DEC, S_TRAP | B_ILL, S_TRAP | B_ILL,
            S_TRAP | B_ILL, S_TRAP | B_ILL, S_TRAP | B_ILL};
    opcode = T_BAD; imem_ack = 1'b1; dmem_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 20'd0) begin
      errors++;
      $display("FAIL illegal async_reset: got %h expected %h", obs, 20'd0);
    end
  endtask

  task automatic test_timeout();
    logic [19:0] exp_a [7];
    logic [19:0] exp_b [6];
    exp_a = '{S_IDLE, S_FETCH | B_IMEM, S_FETCH | B_IMEM, S_FETCH | B_IMEM,
              S_FETCH | B_IMEM, S_TRAP | B_TO, S_TRAP | B_TO};
    exp_b = '{S_IDLE, S_FETCH | B_IMEM, S_FETCH | B_IMEM, S_FETCH | B_IMEM,
              F_ACK, S_DEC};
    opcode = T_R; imem_ack = 1'b0; dmem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_a[i]) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %h expected %h", i, obs, exp_a[i]);
      end
      @(posedge clk); #1;
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      imem_ack = (i == 4);
      @(negedge clk);
      checks++;
      if (obs !== exp_b[i]) begin
        errors++;
        $display("FAIL ack_at_limit cycle %0d: got %h expected %h", i, obs, exp_b[i]);
      end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
  endtask

  // Stalls with ack present in FETCH: ack ignored, counter frozen (else a
  // 4-cycle limit would trap before the late ack).
  task automatic test_fetch_stall();
    logic [19:0] exp [9];
    exp = '{S_IDLE, S_FETCH | B_IMEM, S_FETCH | B_IMEM, S_FETCH | B_IMEM,
            S_FETCH | B_IMEM, S_FETCH | B_IMEM, S_FETCH | B_IMEM, F_ACK, S_DEC};
    opcode = T_R; imem_ack = 1'b0; dmem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      stall_in = (i >= 2 && i <= 4);
      imem_ack = (i >= 2 && i <= 4) || (i == 7);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL fetch_stall cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_sw();
    logic [19:0] exp [8];
    exp = '{S_IDLE, F_ACK, S_DEC, S_EXEC | B_SRC, S_MEM | B_DMEM,
            S_MEM | B_DMEM, S_MEM | B_DMEM | B_MWR, F_ACK};
    opcode = T_SW; imem_ack = 1'b1; dmem_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      stall_in = (i == 4 || i == 5);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL stall_sw cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
  endtask

  task automatic test_jal();
    logic [19:0] exp [6];
    logic [19:0] exp_nj [6];
    exp    = '{S_IDLE, F_ACK, S_DEC, S_EXEC | J_JAL | B_PCW, S_WB | B_REGW | M_PC, F_ACK};
    exp_nj = '{S_IDLE, F_ACK, S_DEC, S_TRAP | B_ILL, S_TRAP | B_ILL, S_TRAP | B_ILL};
    opcode = T_JAL; imem_ack = 1'b1; dmem_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL jal cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      checks++;
      if (nj_obs !== exp_nj[i]) begin
        errors++;
        $display("FAIL jal_nojump cycle %0d: got %h expected %h", i, nj_obs, exp_nj[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // EXEC controls and the following cycle for the remaining classes.
  task automatic test_classes();
    logic [6:0]  ops [4];
    logic [19:0] exp_exec [4];
    logic [19:0] exp_next [4];
    ops      = '{T_I, T_LUI, T_BR, T_JALR};
    exp_exec = '{S_EXEC | B_SRC | A_FN, S_EXEC | B_SRC | A_LUI,
                 S_EXEC | B_BR | A_BR, S_EXEC | J_JALR | B_PCW | B_SRC};
    exp_next = '{S_WB | B_REGW, S_WB | B_REGW, F_ACK, S_WB | B_REGW | M_PC};
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      do_reset();
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (obs !== exp_exec[k]) begin
        errors++;
        $display("FAIL class %b exec: got %h expected %h", ops[k], obs, exp_exec[k]);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs !== exp_next[k]) begin
        errors++;
        $display("FAIL class %b after_exec: got %h expected %h", ops[k], obs, exp_next[k]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_lw_wait();
    test_illegal();
    test_timeout();
    test_fetch_stall();
    test_stall_sw();
    test_jal();
    test_classes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
